// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
//
// Conditional-execution stage placed directly after the instruction decoder.
// It holds the architectural NZCV flag register and evaluates the ARM 4-bit
// condition field against it. The decoder's raw write requests are turned into
// committed write enables for the PC, register file, data memory and flags.
//
// Parameters
//   MULTICYCLE  1: PC/Reg/Mem writes are gated by the registered condition
//                  result (valid from the cycle after Cond is presented).
//               0: PC/Reg/Mem writes are gated by the combinational result.
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high; clears all state
//   Cond      in   4  instruction condition field, Instr[31:28]
//   ALUFlags  in   4  {N,Z,C,V} produced by the ALU this cycle
//   FlagW     in   2  [1] = write N,Z ; [0] = write C,V
//   PCS       in   1  instruction writes PC
//   RegW      in   1  raw register write request
//   MemW      in   1  raw memory write request
//   NextPC    in   1  unconditional PC+4 fetch write from the multicycle FSM
//   PCWrite   out  1  committed PC write enable
//   RegWrite  out  1  committed register file write enable
//   MemWrite  out  1  committed data memory write enable
//   Flags     out  4  current flag register {N,Z,C,V}
//   CondEx    out  1  combinational condition result for Cond and Flags
// -----------------------------------------------------------------------------
module cond_unit #(
  parameter bit MULTICYCLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NextPC,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  // Evaluate an ARM condition code against {N,Z,C,V}. Code 4'b1111 is a
  // defined "never" so the result can never go unknown.
  function automatic logic cond_eval(input logic [3:0] cond,
                                     input logic [3:0] flags);
    logic n;
    logic z;
    logic c;
    logic v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: res = z;                          // EQ
      4'b0001: res = ~z;                         // NE
      4'b0010: res = c;                          // CS
      4'b0011: res = ~c;                         // CC
      4'b0100: res = n;                          // MI
      4'b0101: res = ~n;                         // PL
      4'b0110: res = v;                          // VS
      4'b0111: res = ~v;                         // VC
      4'b1000: res = c & ~z;                     // HI
      4'b1001: res = ~c | z;                     // LS
      4'b1010: res = ~(n ^ v);                   // GE
      4'b1011: res = n ^ v;                      // LT
      4'b1100: res = ~z & ~(n ^ v);              // GT
      4'b1101: res = z | (n ^ v);                // LE
      4'b1110: res = 1'b1;                       // AL
      4'b1111: res = 1'b0;                       // never
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [3:0] flags_r;
  logic       cond_ex_r;
  logic       cond_ex_s;
  logic [1:0] flag_write_s;
  logic       gate_s;

  // Condition result and the flag-write qualification derived from it. Flag
  // writes always use the live result, in both timing modes.
  always_comb begin
    cond_ex_s    = cond_eval(Cond, flags_r);
    flag_write_s = FlagW & {2{cond_ex_s}};
  end

  // Flag register halves update independently; CondExR tracks CondEx every
  // cycle so later cycles of a multicycle instruction see a stable result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r   <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      if (flag_write_s[1]) begin
        flags_r[3:2] <= ALUFlags[3:2];
      end
      if (flag_write_s[0]) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end
      cond_ex_r <= cond_ex_s;
    end
  end

  // Select the gating source. Reset forces the gate low so no register or
  // memory write can escape while reset is held, even in single-cycle mode
  // where the combinational result may still be true.
  always_comb begin
    gate_s = 1'b0;
    if (reset) begin
      gate_s = 1'b0;
    end else if (MULTICYCLE) begin
      gate_s = cond_ex_r;
    end else begin
      gate_s = cond_ex_s;
    end
  end

  // Committed write enables; NextPC bypasses the condition entirely.
  always_comb begin
    PCWrite  = (PCS & gate_s) | NextPC;
    RegWrite = RegW & gate_s;
    MemWrite = MemW & gate_s;
  end

  assign Flags  = flags_r;
  assign CondEx = cond_ex_s;

endmodule
